// File: rtl/vadd_counter_pkg.sv
// vadd_counter_pkg: shared mode constants, helpers and op encoding for the counter bank
package vadd_counter_pkg;
  localparam int LP_MODE_WRAP = 0;
  localparam int LP_MODE_SAT = 1;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_INCR, OP_DECR} cnt_op_t;
  function automatic logic [63:0] f_all_ones(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/vadd_counter_channel.sv
// vadd_counter_channel: one up/down counter with wrap or saturate behaviour and registered flags
module vadd_counter_channel
  import vadd_counter_pkg::*;
#(
  parameter int C_WIDTH = 16,
  parameter int C_STEP_WIDTH = 4,
  parameter int C_SATURATE = 0,
  parameter logic [C_WIDTH-1:0] C_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clken,
  input  logic                    load,
  input  logic                    incr,
  input  logic                    decr,
  input  logic [C_WIDTH-1:0]      load_value,
  input  logic [C_STEP_WIDTH-1:0] step,
  output logic [C_WIDTH-1:0]      count,
  output logic                    is_zero,
  output logic                    is_max,
  output logic                    wrap,
  output logic                    nxt_zero
);
  localparam logic [C_WIDTH-1:0] LP_MAX = C_WIDTH'(f_all_ones(C_WIDTH));
  localparam bit LP_SAT = C_SATURATE != LP_MODE_WRAP;
  cnt_op_t op;
  logic [C_WIDTH:0] step_ext, sum, diff;
  logic [C_WIDTH-1:0] nxt_count;
  logic nxt_wrap;
  // Decode the request and compute next count from the exact (C_WIDTH+1)-bit sum/difference;
  // the top bit is carry on add and borrow on subtract, which is also the clamp condition
  always_comb begin
    op = load ? OP_LOAD : (incr ^ decr) ? (incr ? OP_INCR : OP_DECR) : OP_HOLD;
    step_ext = (C_WIDTH+1)'(step);
    sum = {1'b0, count} + step_ext;
    diff = {1'b0, count} - step_ext;
    nxt_count = !clken ? count
              : op == OP_LOAD ? load_value
              : op == OP_INCR ? ((LP_SAT && sum[C_WIDTH]) ? LP_MAX : sum[C_WIDTH-1:0])
              : op == OP_DECR ? ((LP_SAT && diff[C_WIDTH]) ? '0 : diff[C_WIDTH-1:0])
              : count;
    nxt_wrap = clken && ((op == OP_INCR && sum[C_WIDTH]) || (op == OP_DECR && diff[C_WIDTH]));
    nxt_zero = nxt_count == '0;
  end
  // Flags come from next-count so they always match the registered count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= C_INIT;
      is_zero <= C_INIT == '0;
      is_max <= C_INIT == LP_MAX;
      wrap <= 1'b0;
    end else begin
      count <= nxt_count;
      is_zero <= nxt_zero;
      is_max <= nxt_count == LP_MAX;
      wrap <= nxt_wrap;
    end
  end
endmodule

// File: rtl/vadd_counter_bank.sv
// vadd_counter_bank: bank of independent up/down counters with a registered all-zero flag
module vadd_counter_bank
  import vadd_counter_pkg::*;
#(
  parameter int C_WIDTH = 16,
  parameter int C_CHANNELS = 4,
  parameter int C_STEP_WIDTH = 4,
  parameter int C_SATURATE = LP_MODE_WRAP,
  parameter logic [C_WIDTH-1:0] C_INIT = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clken,
  input  logic [C_CHANNELS-1:0]              load,
  input  logic [C_CHANNELS-1:0]              incr,
  input  logic [C_CHANNELS-1:0]              decr,
  input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
  output logic [C_CHANNELS*C_WIDTH-1:0]      count,
  output logic [C_CHANNELS-1:0]              is_zero,
  output logic [C_CHANNELS-1:0]              is_max,
  output logic [C_CHANNELS-1:0]              wrap,
  output logic                               all_zero
);
  logic [C_CHANNELS-1:0] nxt_zero;
  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
    vadd_counter_channel #(
      .C_WIDTH(C_WIDTH),
      .C_STEP_WIDTH(C_STEP_WIDTH),
      .C_SATURATE(C_SATURATE),
      .C_INIT(C_INIT)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .clken(clken),
      .load(load[i]),
      .incr(incr[i]),
      .decr(decr[i]),
      .load_value(load_value[i*C_WIDTH +: C_WIDTH]),
      .step(step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .count(count[i*C_WIDTH +: C_WIDTH]),
      .is_zero(is_zero[i]),
      .is_max(is_max[i]),
      .wrap(wrap[i]),
      .nxt_zero(nxt_zero[i])
    );
  end
  // Bank-wide zero flag registered from the channels' next-zero so it tracks the counts exactly
  always_ff @(posedge clk) begin
    all_zero <= rst ? (C_INIT == '0) : &nxt_zero;
  end
endmodule

// File: tb/tb_vadd_counter_bank.sv
// tb_vadd_counter_bank: directed checks of wrap, saturate and alternate-reset-value banks
module tb_vadd_counter_bank;
  logic clk = 1'b0, rst = 1'b1, clken = 1'b1;
  logic [1:0] load = '0, incr = '0, decr = '0;
  logic [7:0] load_value = '0;
  logic [3:0] step = '0;
  logic [7:0] cw, cs, cf;
  logic [1:0] zw, zs, zf, mw, ms, mf, ww, ws, wf;
  logic aw, as_s, af;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  vadd_counter_bank #(.C_WIDTH(4), .C_CHANNELS(2), .C_STEP_WIDTH(2), .C_SATURATE(0), .C_INIT(4'h0)) u_wrap (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .load_value(load_value), .step(step), .count(cw), .is_zero(zw), .is_max(mw), .wrap(ww), .all_zero(aw));
  vadd_counter_bank #(.C_WIDTH(4), .C_CHANNELS(2), .C_STEP_WIDTH(2), .C_SATURATE(1), .C_INIT(4'h0)) u_sat (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .load_value(load_value), .step(step), .count(cs), .is_zero(zs), .is_max(ms), .wrap(ws), .all_zero(as_s));
  vadd_counter_bank #(.C_WIDTH(4), .C_CHANNELS(2), .C_STEP_WIDTH(2), .C_SATURATE(0), .C_INIT(4'hF)) u_initf (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .load_value(load_value), .step(step), .count(cf), .is_zero(zf), .is_max(mf), .wrap(wf), .all_zero(af));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [1:0] l, input logic [1:0] i, input logic [1:0] d,
                     input logic [7:0] lv, input logic [3:0] st);
    load = l; incr = i; decr = d; load_value = lv; step = st;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(2'b00, 2'b00, 2'b00, 8'h00, 4'h0);
    chk("rst_count", cw, 8'h00);
    chk("rst_zero", {6'd0, zw}, 8'h03);
    chk("rst_max", {6'd0, mw}, 8'h00);
    chk("rst_wrap", {6'd0, ww}, 8'h00);
    chk("rst_all_zero", {7'd0, aw}, 8'h01);
    chk("rstf_count", cf, 8'hFF);
    chk("rstf_max", {6'd0, mf}, 8'h03);
    chk("rstf_zero", {6'd0, zf}, 8'h00);
    chk("rstf_all_zero", {7'd0, af}, 8'h00);
    cyc(2'b00, 2'b11, 2'b00, 8'h00, 4'h5);
    chk("rst_hold_incr", cw, 8'h00);
    chk("rst_hold_all_zero", {7'd0, aw}, 8'h01);
    rst = 1'b0;
    // wrap mode on ch0
    cyc(2'b01, 2'b00, 2'b00, 8'h0E, 4'h0);
    chk("w_load", cw, 8'h0E);
    cyc(2'b00, 2'b01, 2'b00, 8'h00, 4'h3);
    chk("w_incr_count", cw, 8'h01);
    chk("w_incr_wrap", {6'd0, ww}, 8'h01);
    chk("w_incr_zero", {6'd0, zw}, 8'h02);
    chk("s_incr_count", cs, 8'h0F);
    chk("s_incr_wrap", {6'd0, ws}, 8'h01);
    cyc(2'b00, 2'b00, 2'b01, 8'h00, 4'h2);
    chk("w_decr_count", cw, 8'h0F);
    chk("w_decr_wrap", {6'd0, ww}, 8'h01);
    chk("w_decr_max", {6'd0, mw}, 8'h01);
    chk("s_decr_count", cs, 8'h0D);
    chk("s_decr_wrap", {6'd0, ws}, 8'h00);
    cyc(2'b00, 2'b00, 2'b00, 8'h00, 4'h0);
    chk("w_hold_count", cw, 8'h0F);
    chk("w_hold_wrap", {6'd0, ww}, 8'h00);
    // saturate mode on ch0
    cyc(2'b01, 2'b00, 2'b00, 8'h0E, 4'h0);
    cyc(2'b00, 2'b01, 2'b00, 8'h00, 4'h3);
    chk("s_clamp_count", cs, 8'h0F);
    chk("s_clamp_wrap", {6'd0, ws}, 8'h01);
    chk("s_clamp_max", {6'd0, ms}, 8'h01);
    cyc(2'b00, 2'b01, 2'b00, 8'h00, 4'h1);
    chk("s_at_max_count", cs, 8'h0F);
    chk("s_at_max_wrap", {6'd0, ws}, 8'h01);
    chk("w_after_incr1", cw, 8'h02);
    cyc(2'b01, 2'b00, 2'b00, 8'h02, 4'h0);
    chk("s_load2_wrap", {6'd0, ws}, 8'h00);
    cyc(2'b00, 2'b00, 2'b01, 8'h00, 4'h3);
    chk("s_floor_count", cs, 8'h00);
    chk("s_floor_wrap", {6'd0, ws}, 8'h01);
    chk("s_floor_zero", {6'd0, zs}, 8'h03);
    chk("s_floor_all_zero", {7'd0, as_s}, 8'h01);
    chk("w_borrow_count", cw, 8'h0F);
    // priority on ch1
    cyc(2'b10, 2'b10, 2'b00, 8'h50, 4'h4);
    chk("p_load_over_incr", cw[7:4], 8'h05);
    cyc(2'b00, 2'b10, 2'b10, 8'h00, 4'h4);
    chk("p_both_count", cw[7:4], 8'h05);
    chk("p_both_wrap", {6'd0, ww}, 8'h00);
    cyc(2'b00, 2'b10, 2'b00, 8'h00, 4'h0);
    chk("p_step0_count", cw[7:4], 8'h05);
    chk("p_step0_wrap", {6'd0, ww}, 8'h00);
    cyc(2'b10, 2'b00, 2'b00, 8'h00, 4'h0);
    cyc(2'b00, 2'b01, 2'b00, 8'h00, 4'h3);
    chk("p_wrap_pulse", {6'd0, ww}, 8'h01);
    clken = 1'b0;
    cyc(2'b10, 2'b01, 2'b00, 8'h90, 4'h3);
    chk("p_clken0_count", cw, 8'h02);
    chk("p_clken0_wrap", {6'd0, ww}, 8'h00);
    chk("p_clken0_all_zero", {7'd0, aw}, 8'h00);
    clken = 1'b1;
    // independence and all_zero
    cyc(2'b11, 2'b00, 2'b00, 8'h31, 4'h0);
    chk("i_load", cw, 8'h31);
    cyc(2'b10, 2'b00, 2'b01, 8'h00, 4'h1);
    chk("i_both_zero", cw, 8'h00);
    chk("i_all_zero", {7'd0, aw}, 8'h01);
    chk("i_zero_flags", {6'd0, zw}, 8'h03);
    cyc(2'b00, 2'b10, 2'b00, 8'h00, 4'h4);
    chk("i_ch1_incr", cw, 8'h10);
    chk("i_all_zero_drop", {7'd0, aw}, 8'h00);
    // reset mid-operation
    cyc(2'b11, 2'b00, 2'b00, 8'h77, 4'h0);
    chk("r_pre_count", cw, 8'h77);
    rst = 1'b1;
    cyc(2'b00, 2'b11, 2'b00, 8'h00, 4'h5);
    rst = 1'b0;
    chk("r_count", cw, 8'h00);
    chk("r_wrap", {6'd0, ww}, 8'h00);
    chk("r_zero", {6'd0, zw}, 8'h03);
    chk("r_all_zero", {7'd0, aw}, 8'h01);
    chk("rf_count", cf, 8'hFF);
    chk("rf_max", {6'd0, mf}, 8'h03);
    chk("rf_all_zero", {7'd0, af}, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
